// File: rtl/aes_core_sched.sv
// ---------------------------------------------------------------------------
// aes_core_sched
// Arbitrates two requesters onto one shared AES core. One job is in flight at
// a time: accept (round-robin), load the core, wait for completion with a
// timeout, then hold the result until the granted requester takes it.
//
// State table
//   state   | meaning
//   IDLE    | no job; accept a request from either requester
//   LOAD    | one-cycle load strobe to the core
//   WAIT    | waiting for core_done, counting toward TIMEOUT
//   RESP    | result held on rsp_data until the granted requester takes it
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   reqN_valid/ready/key/text    job request handshake and payload, N=0,1
//   rspN_valid/ready, rsp_data   result handshake (rsp_data shared)
//   core_ld/key/text_in          load strobe and operands to the core
//   core_done/text_out           completion pulse and ciphertext from core
//   busy, err_timeout, job_cnt   status: not idle, abandon pulse, completions
// ---------------------------------------------------------------------------
module aes_core_sched #(
    parameter int TIMEOUT = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [127:0] req0_key,
    input  logic [127:0] req1_key,
    input  logic [127:0] req0_text,
    input  logic [127:0] req1_text,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    input  logic         rsp0_ready,
    input  logic         rsp1_ready,
    output logic [127:0] rsp_data,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out,
    output logic         busy,
    output logic         err_timeout,
    output logic [15:0]  job_cnt
);

    localparam int            CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last;      // requester granted most recently
    logic          r_grant;     // requester owning the in-flight job
    logic [CW-1:0] r_wait_cnt;
    logic [127:0]  r_key;
    logic [127:0]  r_text;
    logic [127:0]  r_rsp;
    logic [15:0]   r_job_cnt;

    logic          w_gnt;
    logic          w_accept;
    logic          w_done;
    logic          w_rsp_take;

    always_comb begin
        w_next      = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        core_ld     = 1'b0;
        err_timeout = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_rsp_take  = 1'b0;
        // On a tie the requester not served last wins; otherwise whoever asks.
        w_gnt       = (req0_valid && req1_valid) ? ~r_last : req1_valid;

        case (r_state)
            ST_IDLE: begin
                // No accept during reset: the job would be dropped anyway.
                if ((req0_valid || req1_valid) && rst) begin
                    w_accept   = 1'b1;
                    req0_ready = ~w_gnt;
                    req1_ready = w_gnt;
                    w_next     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_ld = 1'b1;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over timeout in the final cycle.
                if (core_done) begin
                    w_done = 1'b1;
                    w_next = ST_RESP;
                end else if (r_wait_cnt == TO_VAL) begin
                    err_timeout = 1'b1;
                    w_next      = ST_IDLE;
                end
            end
            ST_RESP: begin
                rsp0_valid = ~r_grant;
                rsp1_valid = r_grant;
                w_rsp_take = r_grant ? rsp1_ready : rsp0_ready;
                if (w_rsp_take) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_grant    <= 1'b0;
            r_wait_cnt <= '0;
            r_key      <= '0;
            r_text     <= '0;
            r_rsp      <= '0;
            r_job_cnt  <= '0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_grant <= w_gnt;
                r_key   <= w_gnt ? req1_key  : req0_key;
                r_text  <= w_gnt ? req1_text : req0_text;
            end

            if (r_state == ST_LOAD) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end

            if (w_done) begin
                r_rsp <= core_text_out;
            end

            // Abandoned and completed jobs both count as a served turn.
            if (err_timeout || w_rsp_take) begin
                r_last <= r_grant;
            end

            if (w_rsp_take) begin
                r_job_cnt <= r_job_cnt + 16'd1;
            end
        end
    end

    assign core_key     = r_key;
    assign core_text_in = r_text;
    assign rsp_data     = r_rsp;
    assign job_cnt      = r_job_cnt;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aes_core_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_core_sched
// Transaction-level bench: each job is described by who requests, how many
// WAIT cycles until the core answers (or never), and how long the requester
// stalls the response. The expected grant, timeline and result follow from
// the round-robin rule and a stub core that returns the FIPS-197 answer for
// the known vector and a fixed mixing function otherwise.
// ---------------------------------------------------------------------------
module tb_aes_core_sched;

    localparam int TIMEOUT = 31;

    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_TXT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_key, req1_key, req0_text, req1_text;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [127:0] rsp_data;
    logic         core_ld;
    logic [127:0] core_key, core_text_in;
    logic         core_done;
    logic [127:0] core_text_out;
    logic         busy, err_timeout;
    logic [15:0]  job_cnt;

    always #5 clk = ~clk;

    aes_core_sched #(.TIMEOUT(TIMEOUT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .req0_key     (req0_key),
        .req1_key     (req1_key),
        .req0_text    (req0_text),
        .req1_text    (req1_text),
        .rsp0_valid   (rsp0_valid),
        .rsp1_valid   (rsp1_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_ready   (rsp1_ready),
        .rsp_data     (rsp_data),
        .core_ld      (core_ld),
        .core_key     (core_key),
        .core_text_in (core_text_in),
        .core_done    (core_done),
        .core_text_out(core_text_out),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .job_cnt      (job_cnt)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_last;
    logic [15:0] m_cnt;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] t);
        if (k == KAT_KEY && t == KAT_TXT) return KAT_CT;
        return {t[63:0], t[127:64]} ^ k ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        core_done  = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_rsp_data", rsp_data, '0);
        check_val("rst_core_key", core_key, '0);
        check_val("rst_core_text", core_text_in, '0);
        check_val("rst_job_cnt", job_cnt, '0);
        check_val("rst_ctl", {busy, core_ld, err_timeout, rsp0_valid, rsp1_valid,
                              req0_ready, req1_ready}, '0);
        rst   = 1'b1;
        m_last = 1'b1;
        m_cnt  = '0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
        core_done  = 1'($urandom_range(0, 1));
        core_text_out = rand128();
        #1;
        check_val("idle_ctl", {busy, core_ld, err_timeout, rsp0_valid, rsp1_valid,
                               req0_ready, req1_ready}, '0);
        check_val("idle_cnt", job_cnt, m_cnt);
    endtask

    // done_dly: WAIT-cycle index at which the core answers; beyond TIMEOUT
    // (or negative) means it never does. rsp_dly: RESP cycles before taking.
    task automatic run_job(input bit v0, input bit v1, input int done_dly, input int rsp_dly,
                           input logic [127:0] k0, input logic [127:0] t0,
                           input logic [127:0] k1, input logic [127:0] t1,
                           output int got_g, output bit got_rsp);
        bit           eg;
        bit           fin;
        bit           done_now;
        int           k;
        logic [127:0] ek, et, exp_rsp;

        eg      = (v0 && v1) ? !m_last : v1;
        ek      = eg ? k1 : k0;
        et      = eg ? t1 : t0;
        exp_rsp = core_model(ek, et);
        got_rsp = 1'b0;

        @(negedge clk);
        req0_valid = v0; req1_valid = v1;
        req0_key = k0; req0_text = t0; req1_key = k1; req1_text = t1;
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
        core_done  = 1'($urandom_range(0, 1));
        core_text_out = rand128();
        #1;
        check_val("acc_busy", busy, 1'b0);
        check_val("acc_ready0", req0_ready, !eg);
        check_val("acc_ready1", req1_ready, eg);
        check_val("acc_cnt", job_cnt, m_cnt);
        got_g = req1_ready ? 1 : 0;

        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_key = rand128(); req0_text = rand128();
        req1_key = rand128(); req1_text = rand128();
        core_done = 1'($urandom_range(0, 1));
        core_text_out = rand128();
        #1;
        check_val("load_ld", core_ld, 1'b1);
        check_val("load_key", core_key, ek);
        check_val("load_text", core_text_in, et);
        check_val("load_misc", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                err_timeout}, 6'b100000);

        fin = 1'b0;
        k   = 0;
        while (!fin) begin
            @(negedge clk);
            done_now = (k == done_dly);
            core_done = done_now;
            core_text_out = done_now ? exp_rsp : rand128();
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            req0_key = rand128(); req1_key = rand128();
            #1;
            check_val("wait_misc", {busy, core_ld, req0_ready, req1_ready, rsp0_valid,
                                    rsp1_valid}, 6'b100000);
            check_val("wait_key", core_key, ek);
            check_val("wait_err", err_timeout, (k == TIMEOUT) && !done_now);
            if (done_now) begin
                fin     = 1'b1;
                got_rsp = 1'b1;
            end else if (k == TIMEOUT) begin
                fin    = 1'b1;
                m_last = eg;
            end
            k++;
        end

        if (got_rsp) begin
            for (int r = 0; r <= rsp_dly; r++) begin
                @(negedge clk);
                core_done = 1'($urandom_range(0, 1));
                core_text_out = rand128();
                rsp0_ready = eg ? 1'b1 : (r == rsp_dly);
                rsp1_ready = eg ? (r == rsp_dly) : 1'b1;
                #1;
                check_val("resp_v0", rsp0_valid, !eg);
                check_val("resp_v1", rsp1_valid, eg);
                check_val("resp_data", rsp_data, exp_rsp);
                check_val("resp_misc", {busy, core_ld, err_timeout, req0_ready, req1_ready},
                          5'b10000);
                check_val("resp_key", core_text_in, et);
                check_val("resp_cnt", job_cnt, m_cnt);
            end
            m_last = eg;
            m_cnt  = m_cnt + 16'd1;
        end
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_key = rand128(); req0_text = rand128();
        core_done = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_val("mid_busy", busy, 1'b1);
        do_reset();
        @(negedge clk);
        core_done = 1'b1;
        core_text_out = rand128();
        #1;
        check_val("late_done_a", {busy, rsp0_valid, rsp1_valid, err_timeout}, '0);
        @(negedge clk);
        core_done = 1'b0;
        #1;
        check_val("late_done_b", {busy, rsp0_valid, rsp1_valid, err_timeout}, '0);
        check_val("late_rsp_data", rsp_data, '0);
        check_val("late_cnt", job_cnt, '0);
    endtask

    initial begin
        int g;
        bit rsp;
        bit v0, v1;
        int dd;

        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_key = '0; req1_key = '0; req0_text = '0; req1_text = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        core_done = 1'b0; core_text_out = '0;
        m_last = 1'b1;
        m_cnt  = '0;

        do_reset();

        // Known-answer single job on requester 0.
        run_job(1'b1, 1'b0, 3, 0, KAT_KEY, KAT_TXT, rand128(), rand128(), g, rsp);
        check_val("kat_grant", g, 0);
        check_val("kat_rsp", rsp, 1'b1);
        idle_cycle();
        check_val("kat_cnt", job_cnt, 16'd1);
        check_val("kat_data", rsp_data, KAT_CT);

        // Contention from reset: tie alternates starting with requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_job(1'b1, 1'b1, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                    rand128(), rand128(), rand128(), rand128(), g, rsp);
            check_val("rr_order", g, i % 2);
        end

        // Backpressure on requester 1 for 10 cycles.
        run_job(1'b0, 1'b1, 2, 10, rand128(), rand128(), rand128(), rand128(), g, rsp);
        check_val("bp_grant", g, 1);
        idle_cycle();

        // Core never answers: abandon, then the tie goes to the other side.
        run_job(1'b1, 1'b0, -1, 0, rand128(), rand128(), rand128(), rand128(), g, rsp);
        check_val("to_no_rsp", rsp, 1'b0);
        run_job(1'b1, 1'b1, 1, 0, rand128(), rand128(), rand128(), rand128(), g, rsp);
        check_val("to_next_grant", g, 1);

        // Done on the final timeout cycle still completes.
        run_job(1'b1, 1'b1, TIMEOUT, 1, rand128(), rand128(), rand128(), rand128(), g, rsp);
        check_val("edge_rsp", rsp, 1'b1);

        // Reset in the middle of WAIT, late completion ignored, then recover.
        reset_mid_wait();
        run_job(1'b1, 1'b0, 4, 0, rand128(), rand128(), rand128(), rand128(), g, rsp);
        check_val("post_rst_rsp", rsp, 1'b1);
        idle_cycle();
        check_val("post_rst_cnt", job_cnt, 16'd1);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            dd = ($urandom_range(0, 4) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 8));
            run_job(v0, v1, dd, int'($urandom_range(0, 4)),
                    rand128(), rand128(), rand128(), rand128(), g, rsp);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_core_sched.md
AES_CORE_SCHED -- requirements
Module: aes_core_sched

Interface
REQ-001 Parameter TIMEOUT, default 31: maximum WAIT-state cycles before abandoning a job.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  in  1  requester N has a job.
REQ-005 req0_ready / req1_ready  out  1  job of requester N accepted this cycle.
REQ-006 req0_key / req1_key  in  128  cipher key of requester N.
REQ-007 req0_text / req1_text  in  128  plaintext of requester N.
REQ-008 rsp0_valid / rsp1_valid  out  1  result available for requester N.
REQ-009 rsp0_ready / rsp1_ready  in  1  requester N takes the result.
REQ-010 rsp_data  out  128  result, shared by both requesters; qualified by rspN_valid.
REQ-011 core_ld  out  1  load strobe to the shared AES core.
REQ-012 core_key / core_text_in  out  128 each  key and plaintext to the core.
REQ-013 core_done  in  1  core completion pulse.
REQ-014 core_text_out  in  128  core ciphertext.
REQ-015 busy  out  1  state is not IDLE.
REQ-016 err_timeout  out  1  one-cycle pulse when a job is abandoned.
REQ-017 job_cnt  out  16  count of completed responses.

Function
REQ-018 FSM states: IDLE, LOAD, WAIT, RESP; encoding is free.
REQ-019 IDLE, any reqN_valid: grant by round-robin; reqN_ready=1 combinationally for the granted N only; capture key and text into holding registers; record grant; go to LOAD.
REQ-020 Round-robin: if both valid, the requester not granted last wins; if one is valid, it wins.
REQ-021 LOAD: core_ld=1 for exactly one cycle; go to WAIT; clear the wait counter.
REQ-022 core_key and core_text_in shall drive the holding registers and stay stable from LOAD until the next IDLE accept.
REQ-023 WAIT: increment the wait counter each cycle; on core_done=1, capture core_text_out into rsp_data and go to RESP.
REQ-024 WAIT timeout: if the counter equals TIMEOUT and core_done=0, pulse err_timeout, emit no response, update last-grant, and go to IDLE.
REQ-025 If core_done=1 in the cycle the timeout is reached, done wins and no error is raised.
REQ-026 core_done is ignored in IDLE, LOAD and RESP.
REQ-027 RESP: rspN_valid=1 for the granted N only, and rsp_data is held.
REQ-028 In RESP, on rspN_ready=1: update last-grant, increment job_cnt, and go to IDLE the next cycle.
REQ-029 rspM_ready of the non-granted requester is ignored.
REQ-030 job_cnt wraps from 0xFFFF to 0x0000.
REQ-031 No new job is accepted until the FSM has returned to IDLE; one job is in flight at most.
REQ-032 Latency: accept at cycle T; core_ld at T+1; core_done at cycle D gives rspN_valid at D+1.

Reset
REQ-033 While rst=0 at a clock edge, the FSM returns to IDLE, from any state and mid-job.
REQ-034 Reset values: all outputs 0, rsp_data=0, core_key=0, core_text_in=0, job_cnt=0.
REQ-035 Reset sets last-grant to requester 1, so requester 0 wins the first tie.
REQ-036 An in-flight job at reset is discarded, and a core_done arriving after reset is ignored.

Verification
REQ-037 Single job: req0 with key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, using a reference core -> req0_ready for 1 cycle, core_ld for 1 cycle, then rsp0_valid with rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, and job_cnt=1.
REQ-038 Contention: both valid every cycle for 4 jobs -> grants in order 0,1,0,1, with no double grant and no response to the wrong requester.
REQ-039 Backpressure: rsp1_ready held 0 for 10 cycles -> rsp1_valid and rsp_data stay stable, req0_ready stays 0, and IDLE resumes 1 cycle after rsp1_ready=1.
REQ-040 Timeout: core_done never asserted, TIMEOUT=31 -> err_timeout pulses once, no rspN_valid, busy drops, and the next job is granted to the other requester.
REQ-041 Boundary: core_done coincides with the final timeout cycle -> response is delivered and err_timeout stays 0.
REQ-042 Reset mid-WAIT, then a late core_done -> all outputs 0, no rspN_valid, job_cnt=0, and the next req0 job completes normally.
